mem_stage_ctrl: RTL and testbench

Memory-stage controller for the 5-stage pipeline. Replaces the purely combinational memory-stage decode with a handshaked data-memory port, so memory may take a variable number of cycles. It decodes the M-stage opcode, issues lw/sw requests through a req/ack interface, stalls the pipeline until the access completes, forwards W-stage results into store data, and selects the writeback value.

---
 rtl/mem_stage_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: decodes the M-stage opcode, runs lw/sw through a req/ack port and
// stalls F..M until the access completes. Optional busy timeout: define MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int OP_W           = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  m_rd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] dataB,
  input  logic              w_writing,
  input  logic [REG_W-1:0]  w_rd,
  input  logic [DATA_W-1:0] w_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              writing,
  output logic              jal,
  output logic [DATA_W-1:0] write_back,
  output logic              mem_err,
  output logic [1:0]        dbg_state
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'd0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'd5);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(5'd3);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(5'd7);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(5'd8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   load_q;
  logic [DATA_W-1:0]   wdata_d;
  logic                is_add, is_addi, is_jal, is_sw, is_lw, start;
  logic                timeout_hit;

  assign is_add  = (opcode == OP_ADD);
  assign is_addi = (opcode == OP_ADDI);
  assign is_jal  = (opcode == OP_JAL);
  assign is_sw   = (opcode == OP_SW);
  assign is_lw   = (opcode == OP_LW);
  assign start   = in_valid & (is_lw | is_sw);

  // W-stage result overrides stale store data; x0 is never a forwarding source.
  assign wdata_d = (w_writing && (w_rd == m_rd) && (w_rd != '0)) ? w_data : dataB;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = (state_q == S_BUSY) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (state_q == S_BUSY && !mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_BUSY;
            mem_req_q <= 1'b1;
            mem_we_q  <= is_sw;
            addr_q    <= alu_out;
            wdata_q   <= wdata_d;
          end
        end
        S_BUSY: begin
          // An ack arriving together with the timeout limit completes normally.
          if (mem_ack) begin
            if (!mem_we_q) begin
              load_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (timeout_hit) begin
            load_q    <= '0;
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign stall      = !reset && ((state_q == S_IDLE && start) || state_q == S_BUSY);
  assign writing    = in_valid & (is_add | is_addi | is_lw | is_jal);
  assign jal        = in_valid & is_jal;
  assign write_back = is_lw ? load_q : alu_out;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-instruction reference model (latency, request, forwarding,
// writeback) checked against randomized and directed instruction streams.
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int OW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic [RW-1:0] m_rd = '0;
  logic [DW-1:0] alu_out = '0;
  logic [DW-1:0] dataB = '0;
  logic          w_writing = 1'b0;
  logic [RW-1:0] w_rd = '0;
  logic [DW-1:0] w_data = '0;
  logic          mem_req, mem_we, stall, writing, jal, mem_err;
  logic [DW-1:0] mem_addr, mem_wdata, write_back;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic exp_err = 1'b0;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .OP_W(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .m_rd(m_rd),
    .alu_out(alu_out), .dataB(dataB), .w_writing(w_writing), .w_rd(w_rd), .w_data(w_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .writing(writing), .jal(jal),
    .write_back(write_back), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  // waits < 0 means the memory never acknowledges.
  task automatic run_op(input logic [OW-1:0] op, input logic [RW-1:0] rd,
                        input logic [DW-1:0] alu, input logic [DW-1:0] db,
                        input logic ww, input logic [RW-1:0] wrd, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rdata, input string name);
    bit is_mem, is_lw, exp_wr, exp_jal, done, stable_ok;
    int exp_stall, exp_req, stalls, reqs, cyc;
    logic [DW-1:0] exp_fwd, exp_wb, got_wb;
    is_lw     = (op == 5'd8);
    is_mem    = is_lw || (op == 5'd7);
    exp_wr    = (op == 5'd0) || (op == 5'd5) || (op == 5'd3) || is_lw;
    exp_jal   = (op == 5'd3);
    exp_fwd   = (ww && wrd == rd && wrd != 0) ? wd : db;
    exp_stall = !is_mem ? 0 : (waits < 0 ? TO + 1 : waits + 2);
    exp_req   = !is_mem ? 0 : (waits < 0 ? TO : waits + 1);
    exp_wb    = !is_lw ? alu : (waits < 0 ? '0 : rdata);
    if (is_mem && waits < 0) exp_err = 1'b1;
    exp_q.push_back(exp_wb);

    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; m_rd = rd; alu_out = alu; dataB = db;
    w_writing = ww; w_rd = wrd; w_data = wd;
    stalls = 0; reqs = 0; cyc = 0; done = 0; stable_ok = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqs++;
        if (mem_addr !== alu || mem_we !== (op == 5'd7) || mem_wdata !== exp_fwd) stable_ok = 0;
        mem_ack   = (waits >= 0 && reqs == waits + 1);
        mem_rdata = mem_ack ? rdata : DW'($urandom);
      end else begin
        // Stray acks outside an access must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end
      if (stall) stalls++;
      else done = 1;
    end
    got_wb = write_back;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s retire: got no retire within 200 cycles, expected retire", name);
    end
    n_checks++;
    if (stalls !== exp_stall) begin
      n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
    end
    n_checks++;
    if (reqs !== exp_req) begin
      n_fail++; $display("FAIL %s req_cycles: got %0d expected %0d", name, reqs, exp_req);
    end
    n_checks++;
    if (is_mem && (!stable_ok || mem_addr !== alu || mem_we !== (op == 5'd7) || mem_wdata !== exp_fwd)) begin
      n_fail++;
      $display("FAIL %s req_fields: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h stable=1",
               name, mem_addr, mem_we, mem_wdata, alu, (op == 5'd7), exp_fwd);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s req_at_retire: got %b expected 0", name, mem_req);
    end
    n_checks++;
    if (writing !== exp_wr || jal !== exp_jal) begin
      n_fail++; $display("FAIL %s decode: got writing=%b jal=%b expected %b %b", name, writing, jal, exp_wr, exp_jal);
    end
    exp_wb = exp_q.pop_front();
    n_checks++;
    if (got_wb !== exp_wb) begin
      n_fail++; $display("FAIL %s write_back: got %h expected %h", name, got_wb, exp_wb);
    end
    n_checks++;
    if (mem_err !== exp_err) begin
      n_fail++; $display("FAIL %s mem_err: got %b expected %b", name, mem_err, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; opcode = 5'd8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_err !== 0 ||
        dbg_state !== 2'd0 || write_back !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b we=%b addr=%h wdata=%h err=%b st=%0d wb=%h stall=%b expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_err, dbg_state, write_back, stall);
    end
  endtask

  task automatic test_add();
    run_op(5'd0, 5'd3, 32'h1234, 32'h9, 1'b0, 5'd0, 32'h0, 0, 32'h0, "add");
    run_op(5'd5, 5'd4, 32'h77, 32'h1, 1'b0, 5'd0, 32'h0, 0, 32'h0, "addi");
    run_op(5'd3, 5'd1, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'h0, "jal");
    run_op(5'd9, 5'd2, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'h0, "other_op");
    go_idle();
  endtask

  task automatic test_lw_wait();
    run_op(5'd8, 5'd6, 32'h40, 32'h0, 1'b0, 5'd0, 32'h0, 3, 32'hDEADBEEF, "lw_wait3");
    go_idle();
  endtask

  task automatic test_sw_forward();
    run_op(5'd7, 5'd7, 32'h80, 32'h55, 1'b1, 5'd7, 32'hAA, 0, 32'h0, "sw_fwd");
    run_op(5'd7, 5'd7, 32'h84, 32'h55, 1'b1, 5'd0, 32'hAA, 1, 32'h0, "sw_wrd0");
    run_op(5'd7, 5'd0, 32'h88, 32'h55, 1'b1, 5'd0, 32'hAA, 0, 32'h0, "sw_x0");
    run_op(5'd7, 5'd7, 32'h8C, 32'h55, 1'b0, 5'd7, 32'hAA, 0, 32'h0, "sw_nowrite");
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_op(5'd8, 5'd9, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'hCAFEF00D, "b2b_lw");
    run_op(5'd7, 5'd9, 32'h204, 32'h1111, 1'b1, 5'd9, 32'h2222, 0, 32'h0, "b2b_sw");
    run_op(5'd8, 5'd10, 32'h208, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'h0BADF00D, "b2b_lw2");
    go_idle();
  endtask

  task automatic test_random();
    logic [OW-1:0] ops[6];
    logic [OW-1:0] op;
    logic [RW-1:0] rd, wrd;
    ops[0] = 5'd0; ops[1] = 5'd5; ops[2] = 5'd3; ops[3] = 5'd7; ops[4] = 5'd8;
    for (int i = 0; i < 40; i++) begin
      ops[5] = OW'($urandom);
      op  = ops[$urandom_range(0, 5)];
      rd  = RW'($urandom_range(0, 3));
      wrd = ($urandom_range(0, 1) == 1) ? rd : RW'($urandom_range(0, 3));
      run_op(op, rd, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), wrd, DW'($urandom),
             $urandom_range(0, 2), DW'($urandom), "random");
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_op(5'd8, 5'd5, 32'h300, 32'h0, 1'b0, 5'd0, 32'h0, -1, 32'h0, "timeout_lw");
    go_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", mem_err);
    end
    run_op(5'd8, 5'd5, 32'h304, 32'h0, 1'b0, 5'd0, 32'h0, 3, 32'h600DD00D, "timeout_edge_ack");
    go_idle();
  endtask
`endif

  task automatic test_reset_busy();
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 5'd8; alu_out = 32'h80; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy_req: got %b expected 1", mem_req);
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy_stall: got %b expected 0", stall);
    end
    @(posedge clk); #1;
    reset = 1'b0; exp_err = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 0 || stall !== 0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_busy_after: got req=%b stall=%b st=%0d expected 0 0 0", mem_req, stall, dbg_state);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (write_back !== 0 || dbg_state !== 2'd0 || mem_req !== 0 || mem_err !== exp_err) begin
      n_fail++; $display("FAIL rst_late_ack: got wb=%h st=%0d req=%b err=%b expected 0 0 0 0",
                         write_back, dbg_state, mem_req, mem_err);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_forward();
    test_back_to_back();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
